dig_dec_clkgen: RTL and testbench

- Combines a registered hex-to-7-segment digit decoder with a digital frequency synthesiser.
- The synthesiser replaces the vendor PLL used for display scanning and timebase.
- It produces two rate ticks plus near-50%-duty square waves from the single system clock, nominally 8 kHz scan and 4096 Hz timebase.
- Sits between the display-digit mux and the segment pins, and feeds the scan/seconds dividers.

---
 rtl/dig_dec_clkgen.sv | 150 +++++++++++++++
 tb/tb_dig_dec_clkgen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dig_dec_clkgen.sv
// Registered hex-to-7-segment decoder plus a two-output phase-accumulator frequency synthesiser.
// Optional DIG_DEC_BLANK_EN adds a 'blank' input that forces the segment register to all-off.

module dig_dec_clkgen_acc #(
  parameter int                ACC_W = 32,
  parameter logic [ACC_W-1:0]  INC   = '0
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o,
  output logic msb_o
);
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             tick_q, carry;

  assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, INC};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= carry;
    end
  end

  assign tick_o = tick_q;
  assign msb_o  = acc_q[ACC_W-1];
endmodule

module dig_dec_clkgen #(
  parameter int CLK_HZ      = 50000000,
  parameter int F0_HZ       = 8000,
  parameter int F1_HZ       = 4096,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] val,
  input  logic       dp,
`ifdef DIG_DEC_BLANK_EN
  input  logic       blank,
`endif
  output logic [7:0] dig,
  output logic       tick0,
  output logic       tick1,
  output logic       c0,
  output logic       c1,
  output logic       locked
);
  localparam int NUM_LANES = 2;
  localparam int LW        = $clog2(LOCK_CYCLES + 1);

  // Round-to-nearest increment; 64-bit math keeps F * 2^ACC_W exact.
  localparam longint unsigned INC0_L =
    ((longint'(F0_HZ) * (64'd1 << ACC_W)) + longint'(CLK_HZ / 2)) / longint'(CLK_HZ);
  localparam longint unsigned INC1_L =
    ((longint'(F1_HZ) * (64'd1 << ACC_W)) + longint'(CLK_HZ / 2)) / longint'(CLK_HZ);
  localparam longint unsigned HALF_L = 64'd1 << (ACC_W - 1);

  localparam logic [NUM_LANES-1:0][ACC_W-1:0] INC_V =
    {INC1_L[ACC_W-1:0], INC0_L[ACC_W-1:0]};

  generate
    if (INC0_L == 0 || INC0_L >= HALF_L || INC1_L == 0 || INC1_L >= HALF_L) begin : g_bad_inc
      $error("dig_dec_clkgen: increment out of range (0 or >= 2^(ACC_W-1))");
    end
  endgenerate

  logic [NUM_LANES-1:0] tick_v, msb_v;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      dig_dec_clkgen_acc #(.ACC_W(ACC_W), .INC(INC_V[g])) u_acc (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick_v[g]),
        .msb_o  (msb_v[g])
      );
    end
  endgenerate

  assign tick0 = tick_v[0];
  assign tick1 = tick_v[1];
  assign c0    = msb_v[0];
  assign c1    = msb_v[1];

  // Lock counter saturates at LOCK_CYCLES; locked is sticky until reset.
  logic [LW-1:0] cnt_q, cnt_d;
  logic          locked_q, locked_d;

  always_comb begin
    cnt_d    = (cnt_q == LW'(LOCK_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    locked_d = locked_q | (cnt_d == LW'(LOCK_CYCLES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end

  assign locked = locked_q;

  // Active-low segments, bit order g..a.
  logic [6:0] seg;
  logic [7:0] dig_q, dig_d;

  always_comb begin
    seg = 7'h7F;
    case (val)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
`ifdef DIG_DEC_BLANK_EN
    dig_d = blank ? 8'hFF : {~dp, seg};
`else
    dig_d = {~dp, seg};
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dig_q <= 8'hFF;
    else     dig_q <= dig_d;
  end

  assign dig = dig_q;
endmodule

// File: tb/tb_dig_dec_clkgen.sv
// Directed bench for dig_dec_clkgen: decoder table, lock timing, tick/square-wave timing, async reset.
// Expected tick edges are hand-derived as ceil(n * 2^32 / INC) with INC0=687195, INC1=351844.

module tb_dig_dec_clkgen;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] val;
  logic       dp;
`ifdef DIG_DEC_BLANK_EN
  logic       blank = 1'b0;
`endif
  logic [7:0] dig;
  logic       tick0, tick1, c0, c1, locked;

  int checks = 0;
  int failures = 0;

  logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  dig_dec_clkgen dut (
    .clk    (clk),
    .rst    (rst),
    .val    (val),
    .dp     (dp),
`ifdef DIG_DEC_BLANK_EN
    .blank  (blank),
`endif
    .dig    (dig),
    .tick0  (tick0),
    .tick1  (tick1),
    .c0     (c0),
    .c1     (c1),
    .locked (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  // Runs n clocks after reset release, sampling 1 time unit after each rising edge.
  task automatic run_win(input int n, input bit do_sweep, input int exp_n0, input int exp_n1);
    int last0 = 0, last1 = 0, n0 = 0, n1 = 0, c0_rise = 0, c1_rise = 0;
    bit p0 = 0, p1 = 0, pc0 = 0, pc1 = 0, c1_done = 0;
    logic [7:0] exp_dig = 8'h00;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (i == 1) chk("dig_after_release", dig, 8'hC0);
      else if (do_sweep && i <= 33) chk("dig_sweep", dig, exp_dig);
      if (do_sweep && i <= 32) begin
        val = 4'((i - 1) % 16);
        dp  = (i > 16);
        exp_dig = SEG[(i - 1) % 16] & (dp ? 8'h7F : 8'hFF);
      end
      if (i == 1023) chk("locked_early", locked, 1'b0);
      if (i == 1024) chk("locked_rise", locked, 1'b1);
      if (tick0) begin
        chk("tick0_width", p0, 1'b0);
        n0++;
        if (last0 == 0) chk("tick0_first", i, 6250);
        else chk("tick0_gap", (i - last0 == 6249) || (i - last0 == 6250), 1);
        last0 = i;
      end
      if (tick1) begin
        chk("tick1_width", p1, 1'b0);
        n1++;
        if (last1 == 0) chk("tick1_first", i, 12208);
        else chk("tick1_gap", (i - last1 == 12207) || (i - last1 == 12208), 1);
        last1 = i;
      end
      if (c0 && !pc0 && c0_rise == 0) begin
        c0_rise = i;
        chk("c0_first_rise", i, 3125);
      end
      if (c1 && !pc1 && c1_rise == 0) begin
        c1_rise = i;
        chk("c1_first_rise", i, 6104);
      end
      if (!c1 && pc1 && c1_rise != 0 && !c1_done) begin
        c1_done = 1;
        chk("c1_high_time", i - c1_rise, 6104);
      end
      p0 = tick0; p1 = tick1; pc0 = c0; pc1 = c1;
    end
    chk("tick0_count", n0, exp_n0);
    chk("tick1_count", n1, exp_n1);
    chk("locked_hold", locked, 1'b1);
  endtask

  initial begin
    rst = 1'b1; val = 4'h0; dp = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dig", dig, 8'hFF);
    chk("rst_tick0", tick0, 1'b0);
    chk("rst_tick1", tick1, 1'b0);
    chk("rst_c0", c0, 1'b0);
    chk("rst_c1", c1, 1'b0);
    chk("rst_locked", locked, 1'b0);
    #2 rst = 1'b0;

    // Ends just after edge 31250, where the 5th tick0 is high.
    run_win(31250, 1'b1, 5, 2);
    chk("tick0_pre_async", tick0, 1'b1);

    #2;
    val = 4'h0; dp = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_dig", dig, 8'hFF);
    chk("async_tick0", tick0, 1'b0);
    chk("async_locked", locked, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    run_win(6250, 1'b0, 1, 0);

`ifdef DIG_DEC_BLANK_EN
    #1;
    val = 4'h3; dp = 1'b0; blank = 1'b1;
    @(posedge clk); #1;
    chk("blank_on", dig, 8'hFF);
    blank = 1'b0;
    @(posedge clk); #1;
    chk("blank_off", dig, 8'hB0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
